// File: rtl/adc_spi_responder.sv
// SPI slave stand-in for a 12-bit serial ADC: queues parallel samples and serialises one per CS frame.
// Optional per-frame statistics outputs are enabled by defining ADC_RESP_STATS_EN.
module adc_spi_responder #(
  parameter int DATA_W      = 12,
  parameter int LEAD_ZEROS  = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs,
  input  logic                     sck,
  output logic                     sdo,
  output logic                     sdo_oe,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_done,
  output logic                     underrun
`ifdef ADC_RESP_STATS_EN
  ,
  output logic [15:0]              frame_cnt,
  output logic [7:0]               abort_cnt
`endif
);

  localparam int FRAME_W = LEAD_ZEROS + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Input synchronisers; SYNC_STAGES must be at least 2.
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync;
  logic                   cs_prev, sck_prev;
  logic                   cs_fall, cs_rise, sck_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      cs_prev  <= 1'b1;
      sck_prev <= 1'b0;
    end else begin
      // NOTE: clocked state always uses non-blocking assignments so every flop samples pre-edge values.
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_prev  <= cs_sync[SYNC_STAGES-1];
      sck_prev <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign cs_fall  =  cs_prev & ~cs_sync[SYNC_STAGES-1];
  assign cs_rise  = ~cs_prev &  cs_sync[SYNC_STAGES-1];
  assign sck_fall =  sck_prev & ~sck_sync[SYNC_STAGES-1];

  // Sample FIFO
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              push, pop, start, nonempty;
  logic [DATA_W-1:0] last_sample, head;
  state_t            state;

  assign nonempty = (level != '0);
  assign s_ready  = (level != LEVEL_W'(DEPTH));
  assign push     = s_valid & s_ready;
  assign start    = (state == IDLE) & cs_fall;
  assign pop      = start & nonempty;
  assign head     = nonempty ? mem[rd_ptr] : last_sample;

  // NOTE: storage array has no reset; occupancy is governed by the reset pointers and level alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Frame FSM with registered SDO and status pulses
  logic [FRAME_W-1:0] frame;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] next_word;

  assign next_word = {{LEAD_ZEROS{1'b0}}, head};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      frame       <= '0;
      bit_cnt     <= '0;
      last_sample <= '0;
      sdo         <= 1'b0;
      sdo_oe      <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
`ifdef ADC_RESP_STATS_EN
      frame_cnt   <= '0;
      abort_cnt   <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        IDLE: begin
          // A coincident sck edge is deliberately ignored here.
          if (cs_fall) begin
            frame       <= next_word;
            last_sample <= head;
            underrun    <= ~nonempty;
            bit_cnt     <= CNT_W'(FRAME_W - 1);
            sdo         <= next_word[FRAME_W-1];
            sdo_oe      <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            sdo    <= 1'b0;
            sdo_oe <= 1'b0;
            state  <= IDLE;
`ifdef ADC_RESP_STATS_EN
            if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 1'b1;
`endif
          end else if (sck_fall) begin
            if (bit_cnt == '0) begin
              sdo        <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
`ifdef ADC_RESP_STATS_EN
              frame_cnt  <= frame_cnt + 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              sdo     <= frame[bit_cnt - 1'b1];
            end
          end
        end
        DONE: begin
          sdo <= 1'b0;
          if (cs_rise) begin
            sdo_oe <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboard bench for adc_spi_responder: an SPI master drives frames, a queue model predicts words.
module tb_adc_spi_responder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs  = 1'b1;
  logic        sck = 1'b0;
  logic        s_valid = 1'b0;
  logic [11:0] s_data  = '0;
  logic        sdo, sdo_oe, s_ready, frame_done, underrun;
  logic [2:0]  level;
`ifdef ADC_RESP_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  abort_cnt;
`endif

  adc_spi_responder dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .sck        (sck),
    .sdo        (sdo),
    .sdo_oe     (sdo_oe),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .level      (level),
    .frame_done (frame_done),
    .underrun   (underrun)
`ifdef ADC_RESP_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .abort_cnt  (abort_cnt)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic [11:0] model_q [$];
  logic [11:0] last_s = '0;
  logic [15:0] exp_q [$];
  bit          ur_q [$];
  int          frames_model = 0;
  int          aborts_model = 0;
  logic [15:0] cap = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Master-side capture on sck rising edges: the last 16 bits form the received word.
  initial forever begin
    @(posedge sck);
    cap = {cap[14:0], sdo};
  end

  // Monitor: pops the scoreboard whenever the DUT announces a finished frame or an underrun.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (frame_done) begin
        if (exp_q.size() == 0) check("spurious_frame_done", 32'(frame_done), 32'd0);
        else check("frame_word", 32'(cap), 32'(exp_q.pop_front()));
      end
      if (underrun) begin
        if (ur_q.size() == 0) check("spurious_underrun", 32'(underrun), 32'd0);
        else void'(ur_q.pop_front());
      end
    end
  end

  task automatic write(input logic [11:0] d);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    if (model_q.size() < DEPTH) model_q.push_back(d);
    @(negedge clk);
    s_valid = 1'b0;
    check("level_after_write", 32'(level), 32'(model_q.size()));
    check("s_ready", 32'(s_ready), 32'(model_q.size() < DEPTH));
  endtask

  task automatic run_frame(input int nfalls, input bit with_write, input logic [11:0] wdata,
                           input bit do_reset);
    @(negedge clk);
    cs = 1'b0;
    if (model_q.size() > 0) last_s = model_q.pop_front();
    else ur_q.push_back(1'b1);
    if (nfalls == 16 && !do_reset) begin
      exp_q.push_back({4'h0, last_s});
      frames_model++;
    end
    if (with_write) begin
      // Land the write on the same clk as the synchronised frame-start pop.
      repeat (2) @(negedge clk);
      s_valid = 1'b1;
      s_data  = wdata;
      if (model_q.size() < DEPTH) model_q.push_back(wdata);
      @(negedge clk);
      s_valid = 1'b0;
      check("level_write_and_pop", 32'(level), 32'(model_q.size()));
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    check("sdo_oe_active", 32'(sdo_oe), 32'd1);
    for (int i = 0; i < nfalls; i++) begin
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
      repeat (4) @(negedge clk);
    end
    if (do_reset) begin
      rst = 1'b0;
      #1;
      check("rst_sdo", 32'(sdo), 32'd0);
      check("rst_sdo_oe", 32'(sdo_oe), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      model_q.delete();
      last_s       = '0;
      frames_model = 0;
      aborts_model = 0;
      cs = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
    end else begin
      if (nfalls < 16) aborts_model++;
      repeat (4) @(negedge clk);
      cs = 1'b1;
      repeat (6) @(negedge clk);
      check("sdo_oe_idle", 32'(sdo_oe), 32'd0);
      check("sdo_idle", 32'(sdo), 32'd0);
      check("level_after_frame", 32'(level), 32'(model_q.size()));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_sdo", 32'(sdo), 32'd0);
    check("reset_sdo_oe", 32'(sdo_oe), 32'd0);
    check("reset_s_ready", 32'(s_ready), 32'd1);
    check("reset_level", 32'(level), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_underrun", 32'(underrun), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single frame
    write(12'hABC);
    run_frame(16, 1'b0, '0, 1'b0);

    // Fill to full, fifth write dropped, drain in order
    write(12'h123);
    write(12'h456);
    write(12'h789);
    write(12'hFFF);
    write(12'h222);
    repeat (4) run_frame(16, 1'b0, '0, 1'b0);

    // Underrun repeats the last sample
    write(12'h5A5);
    run_frame(16, 1'b0, '0, 1'b0);
    run_frame(16, 1'b0, '0, 1'b0);

    // Abort consumes the popped sample
    write(12'h3C3);
    write(12'h111);
    run_frame(6, 1'b0, '0, 1'b0);
    run_frame(16, 1'b0, '0, 1'b0);
`ifdef ADC_RESP_STATS_EN
    check("abort_cnt", 32'(abort_cnt), 32'(aborts_model));
    check("frame_cnt", 32'(frame_cnt), 32'(frames_model));
`endif

    // Write coincident with the frame-start pop at level 2
    write(12'h0A1);
    write(12'h0B2);
    run_frame(16, 1'b1, 12'h0C3, 1'b0);
    run_frame(16, 1'b0, '0, 1'b0);
    run_frame(16, 1'b0, '0, 1'b0);

    // Reset mid-frame, then an underrun frame returning zero
    write(12'h777);
    write(12'h888);
    run_frame(8, 1'b0, '0, 1'b1);
    run_frame(16, 1'b0, '0, 1'b0);

    // Randomised traffic
    for (int it = 0; it < 20; it++) begin
      int n;
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) write(12'($urandom_range(0, 4095)));
      if ($urandom_range(0, 4) == 0) run_frame($urandom_range(1, 15), 1'b0, '0, 1'b0);
      else run_frame(16, 1'b0, '0, 1'b0);
    end

    repeat (10) @(negedge clk);
    check("pending_frames", 32'(exp_q.size()), 32'd0);
    check("pending_underruns", 32'(ur_q.size()), 32'd0);
`ifdef ADC_RESP_STATS_EN
    check("final_frame_cnt", 32'(frame_cnt), 32'(frames_model));
    check("final_abort_cnt", 32'(abort_cnt), 32'(aborts_model));
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Behavioural stand-in for the serial 12-bit ADC: the SPI slave that answers the ADC read master's CS/SCK with SDO.
- Lets the data-collection path run in hardware-in-loop twinning without a physical converter.
- Parallel 12-bit samples from a local source are queued in a small FIFO.
- Each CS frame serialises one sample MSB-first after leading zeros, matching the converter's 16-clock frame.

Parameters:
- DATA_W, 12, sample width in bits.
- LEAD_ZEROS, 4, zero bits sent before data; frame length = LEAD_ZEROS+DATA_W = 16.
- DEPTH, 4, sample FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, flip-flops in the CS/SCK synchronisers.

Ports:
- clk  in  1  system clock; must be at least 8x the SCK frequency.
- rst  in  1  reset, asynchronous, active-low.
- cs  in  1  chip select from master, active-low, asynchronous to clk.
- sck  in  1  serial clock from master, asynchronous to clk.
- sdo  out  1  serial data to master.
- sdo_oe  out  1  high while a frame is active; models SDO tri-state.
- s_data  in  DATA_W  sample to enqueue.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO not full.
- level  out  clog2(DEPTH)+1  FIFO occupancy.
- frame_done  out  1  one-clk pulse when all 16 bits have been shifted.
- underrun  out  1  one-clk pulse when a frame starts with the FIFO empty.

Behaviour:
- Reset values: sdo=0, sdo_oe=0, s_ready=1, level=0, frame_done=0, underrun=0. FIFO is empty, last-sample register=0, FSM=IDLE. Synchronisers reset to cs=1, sck=0.
- cs and sck each pass through a SYNC_STAGES synchroniser. Edges are detected from the last two synchronised samples.
- FIFO write occurs when s_valid and s_ready are both high.
- FIFO pop occurs only at frame start. A simultaneous write and pop leaves level unchanged.
- Writes while full are ignored.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE to SHIFT on synchronised cs falling edge:
  - If FIFO is non-empty, pop the head into the shift register and the last-sample register.
  - If FIFO is empty, reload the last-sample register into the shift register and pulse underrun.
  - Frame word = {LEAD_ZEROS zeros, sample}. Set bit counter to 15, sdo_oe=1, sdo=frame bit 15.
- In SHIFT, each synchronised sck falling edge decrements the counter and drives the next lower frame bit on sdo.
- The registered sdo changes on the clk after edge detection, i.e. SYNC_STAGES+1 clk after clk first samples the new raw level.
- sck rising edges are ignored; the master samples on rising edges.
- SHIFT to DONE: on the sck falling edge with counter=0, drive sdo=0 and pulse frame_done. This is the 16th falling edge after cs fall.
- DONE to IDLE on cs rising edge: sdo_oe=0, sdo=0. Extra sck edges in DONE keep sdo=0.
- Abort: a cs rising edge in SHIFT goes to IDLE immediately with sdo_oe=0 and no frame_done. The popped sample is consumed, not restored.
- cs falling and an sck edge in the same clk: frame start takes priority and that sck edge is ignored.
- Reset asserted mid-frame returns all state to reset values immediately. FIFO contents are discarded.
- FIFO pointers wrap modulo DEPTH. level saturates at DEPTH by construction (s_ready=0 when full).

Optional Feature:
- Macro ADC_RESP_STATS_EN.
- When defined, adds output frame_cnt[15:0], incremented on each frame_done and wrapping at 0xFFFF to 0.
- Also adds output abort_cnt[7:0], incremented on each abort and saturating at 255. Both reset to 0.
- When not defined, neither port nor its counter exists; all other behaviour is identical.

Test Plan:
- Enqueue 0xABC, run one 16-SCK frame (clk = 8x SCK) -> master shifts in 0x0ABC. frame_done pulses once; level goes 1 to 0; sdo_oe falls after cs rises.
- Enqueue 0x123, 0x456, 0x789, 0xFFF, then a fifth write -> s_ready=0 at level=4 and the fifth is dropped. Four frames return 0x0123, 0x0456, 0x0789, 0x0FFF in order.
- After a frame carrying 0x5A5, run a frame with the FIFO empty -> underrun pulses once and master reads 0x05A5 again.
- Enqueue 0x3C3 and 0x111; raise cs after 6 SCK falls -> no frame_done and sdo_oe=0. The next frame returns 0x0111; abort_cnt=1 with ADC_RESP_STATS_EN.
- Assert rst during bit 8 of a frame -> sdo=0, sdo_oe=0, level=0. The next frame underruns and returns 0x0000.
- Simultaneous s_valid write and frame-start pop at level=2 -> level stays 2 and the pop returns the oldest entry.
